// File: rtl/bank_biu_rd_if.sv
// bank_biu_rd_if: HTU request, AXI AR/R, ISU line and error signals of the linefill read BIU
interface bank_biu_rd_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  htu_biu_valid_i;
   logic                  htu_biu_ready_o;
   logic [ADDR_WIDTH-1:0] htu_biu_addr_i;
   logic [2:0]            htu_biu_set_i;
   logic [2:0]            htu_biu_way_i;
   logic                  axi_arvalid_o;
   logic                  axi_arready_i;
   logic [ADDR_WIDTH-1:0] axi_araddr_o;
   logic [5:0]            axi_arid_o;
   logic [7:0]            axi_arlen_o;
   logic [2:0]            axi_arsize_o;
   logic [1:0]            axi_arburst_o;
   logic                  axi_rvalid_i;
   logic                  axi_rready_o;
   logic [127:0]          axi_rdata_i;
   logic [5:0]            axi_rid_i;
   logic                  axi_rlast_i;
   logic [1:0]            axi_rresp_i;
   logic                  biu_isu_rvalid_o;
   logic                  biu_isu_rready_i;
   logic [255:0]          biu_isu_rdata_o;
   logic [5:0]            biu_isu_rid_o;
   logic                  biu_err_o;
   logic [5:0]            biu_err_id_o;
   modport slave (
      input  htu_biu_valid_i, htu_biu_addr_i, htu_biu_set_i, htu_biu_way_i,
      output htu_biu_ready_o,
      output axi_arvalid_o, axi_araddr_o, axi_arid_o, axi_arlen_o, axi_arsize_o, axi_arburst_o,
      input  axi_arready_i,
      input  axi_rvalid_i, axi_rdata_i, axi_rid_i, axi_rlast_i, axi_rresp_i,
      output axi_rready_o,
      output biu_isu_rvalid_o, biu_isu_rdata_o, biu_isu_rid_o,
      input  biu_isu_rready_i,
      output biu_err_o, biu_err_id_o
   );
   modport master (
      output htu_biu_valid_i, htu_biu_addr_i, htu_biu_set_i, htu_biu_way_i,
      input  htu_biu_ready_o,
      input  axi_arvalid_o, axi_araddr_o, axi_arid_o, axi_arlen_o, axi_arsize_o, axi_arburst_o,
      output axi_arready_i,
      output axi_rvalid_i, axi_rdata_i, axi_rid_i, axi_rlast_i, axi_rresp_i,
      input  axi_rready_o,
      input  biu_isu_rvalid_o, biu_isu_rdata_o, biu_isu_rid_o,
      output biu_isu_rready_i,
      input  biu_err_o, biu_err_id_o
   );
endinterface

// File: rtl/bank_biu_rd.sv
// bank_biu_rd: linefill read BIU (HTU -> AXI AR, 2x128b R beats -> 256b ISU line); BANK_BIU_RRESP_CHK_EN enables response checking
module bank_biu_rd #(
   parameter int ADDR_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 8
) (
   input logic          clk_i,
   input logic          rst_i,
   bank_biu_rd_if.slave bus
);
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
   typedef enum logic [1:0] {BEAT0, BEAT1, OUT} state_t;
   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  arvalid_q, arvalid_d;
   logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
   logic [5:0]            arid_q, arid_d;
   logic [7:0]            arlen_q, arlen_d;
   logic [2:0]            arsize_q, arsize_d;
   logic [1:0]            arburst_q, arburst_d;
   logic [255:0]          rdata_q, rdata_d;
   logic [5:0]            rid_q, rid_d;
   logic                  htu_acc, beat, isu_hs;
   logic                  unused_addr;
   assign unused_addr = ^bus.htu_biu_addr_i[4:0];
   assign bus.htu_biu_ready_o  = (~arvalid_q | bus.axi_arready_i) & (cnt_q < MAX_CNT);
   assign bus.axi_arvalid_o    = arvalid_q;
   assign bus.axi_araddr_o     = araddr_q;
   assign bus.axi_arid_o       = arid_q;
   assign bus.axi_arlen_o      = arlen_q;
   assign bus.axi_arsize_o     = arsize_q;
   assign bus.axi_arburst_o    = arburst_q;
   assign bus.axi_rready_o     = state_q != OUT;
   assign bus.biu_isu_rvalid_o = state_q == OUT;
   assign bus.biu_isu_rdata_o  = rdata_q;
   assign bus.biu_isu_rid_o    = rid_q;
   assign htu_acc = bus.htu_biu_valid_i & bus.htu_biu_ready_o;
   assign beat    = bus.axi_rvalid_i & bus.axi_rready_o;
   assign isu_hs  = bus.biu_isu_rvalid_o & bus.biu_isu_rready_i;
   // next state: AR slot reloads on acceptance, line assembled beat by beat and held until the ISU takes it
   always_comb begin
      cnt_d     = cnt_q + CW'(htu_acc) - CW'(isu_hs);
      arvalid_d = htu_acc | (arvalid_q & ~bus.axi_arready_i);
      araddr_d  = htu_acc ? {bus.htu_biu_addr_i[ADDR_WIDTH-1:5], 5'b0} : araddr_q;
      arid_d    = htu_acc ? {bus.htu_biu_set_i, bus.htu_biu_way_i} : arid_q;
      arlen_d   = htu_acc ? 8'd1 : arlen_q;
      arsize_d  = htu_acc ? 3'd4 : arsize_q;
      arburst_d = htu_acc ? 2'b01 : arburst_q;
      state_d   = state_q;
      rdata_d   = rdata_q;
      rid_d     = rid_q;
      if (beat && state_q == BEAT0) begin
         rdata_d[127:0] = bus.axi_rdata_i;
         rid_d          = bus.axi_rid_i;
         state_d        = BEAT1;
      end else if (beat && state_q == BEAT1) begin
         rdata_d[255:128] = bus.axi_rdata_i;
         state_d          = OUT;
      end else if (isu_hs) begin
         state_d = BEAT0;
      end
   end
   // state registers; reset drops any in-flight request, burst or line
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= BEAT0;
         cnt_q     <= '0;
         arvalid_q <= 1'b0;
         araddr_q  <= '0;
         arid_q    <= '0;
         arlen_q   <= '0;
         arsize_q  <= '0;
         arburst_q <= '0;
         rdata_q   <= '0;
         rid_q     <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         arvalid_q <= arvalid_d;
         araddr_q  <= araddr_d;
         arid_q    <= arid_d;
         arlen_q   <= arlen_d;
         arsize_q  <= arsize_d;
         arburst_q <= arburst_d;
         rdata_q   <= rdata_d;
         rid_q     <= rid_d;
      end
   end
`ifdef BANK_BIU_RRESP_CHK_EN
   logic       err_q, err_d, bad;
   logic [5:0] err_id_q, err_id_d;
   assign bad = beat & ((bus.axi_rresp_i != 2'b00) |
                        (state_q == BEAT1 && bus.axi_rid_i != rid_q) |
                        (bus.axi_rlast_i != (state_q == BEAT1)));
   // sticky error flag; the ID is latched only for the first bad beat
   always_comb begin
      err_d    = err_q | bad;
      err_id_d = (bad & ~err_q) ? bus.axi_rid_i : err_id_q;
   end
   // error registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_q    <= 1'b0;
         err_id_q <= '0;
      end else begin
         err_q    <= err_d;
         err_id_q <= err_id_d;
      end
   end
   assign bus.biu_err_o    = err_q;
   assign bus.biu_err_id_o = err_id_q;
`else
   logic unused_chk;
   assign unused_chk       = ^{bus.axi_rresp_i, bus.axi_rlast_i};
   assign bus.biu_err_o    = 1'b0;
   assign bus.biu_err_id_o = '0;
`endif
endmodule
